// File: rtl/bridge_multi_if.sv
// CPU-side request/response bus of the system bridge.
// One request is outstanding at a time; completion is a single-cycle ready pulse.
interface bridge_multi_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_fault;

    modport master (output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
                    input  cpu_rdata, cpu_ready, cpu_fault);
    modport slave  (input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
                    output cpu_rdata, cpu_ready, cpu_fault);
endinterface

// File: rtl/bridge_multi.sv
// System bridge: decodes CPU accesses to DM, NUM_DEV word devices and the
// interrupt controller, and drives the CP0 hwint lines from masked pending bits.
module bridge_multi #(
    parameter int          NUM_DEV    = 2,
    parameter logic [31:0] DM_SIZE    = 32'h3000,
    parameter logic [31:0] DEV_BASE   = 32'h7F00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] DEV_SPAN   = 32'hC,
    parameter logic [31:0] INTC_BASE  = 32'h7F80,
    parameter int          DEV_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    bridge_multi_if.slave           cpu,
    output logic [3:0]              dm_byteen,
    input  logic [31:0]             dm_rdata,
    output logic [31:0]             dev_addr,
    output logic [31:0]             dev_wdata,
    output logic [NUM_DEV-1:0]      dev_we,
    input  logic [32*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      irq,
    input  logic                    ext_irq,
    output logic [5:0]              hwint
);
    localparam int         SELW   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int         NSRC   = NUM_DEV + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] LAT_M1 = (DEV_LAT > 0) ? 4'(DEV_LAT - 1) : 4'd0;

    logic [1:0]      state;
    logic [31:0]     addr_q, rdata_q;
    logic [SELW-1:0] sel_q, dev_sel, rd_sel;
    logic            fault_q, dm_rd_q;
    logic [3:0]      cnt;
    logic [NSRC-1:0] pending, mask, src_q, src, rise, clr;

    logic [NUM_DEV-1:0] hit_dev_raw;
    logic hit_dm, hit_dev, hit_intc, is_wr, acc, fault, intc_wr, dev_rd_wait;
    logic [31:0] intc_rd, dev_word;

    genvar g;
    generate
        for (g = 0; g < NUM_DEV; g++) begin : g_dec
            localparam logic [31:0] BASE = DEV_BASE + 32'(g) * DEV_STRIDE;
            assign hit_dev_raw[g] = (cpu.cpu_addr >= BASE) && ((cpu.cpu_addr - BASE) < DEV_SPAN);
        end
    endgenerate

    // First match wins: DM, then lowest-numbered device, then INTC.
    always_comb begin
        hit_dm  = cpu.cpu_addr < DM_SIZE;
        dev_sel = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--)
            if (hit_dev_raw[i]) dev_sel = SELW'(i);
        hit_dev  = !hit_dm && (|hit_dev_raw);
        hit_intc = !hit_dm && !hit_dev && (cpu.cpu_addr[31:3] == INTC_BASE[31:3]);
    end

    assign is_wr  = |cpu.cpu_byteen;
    assign acc    = (state == S_IDLE) && cpu.cpu_req;
    assign fault  = !(hit_dm || hit_dev || hit_intc) ||
                    ((hit_dev || hit_intc) &&
                     ((cpu.cpu_addr[1:0] != 2'b00) || (is_wr && cpu.cpu_byteen != 4'hF)));
    assign dev_rd_wait = hit_dev && !is_wr && !fault && (DEV_LAT > 0);

    assign dm_byteen = (acc && hit_dm) ? cpu.cpu_byteen : 4'h0;
    always_comb begin
        dev_we = '0;
        if (acc && hit_dev && is_wr && !fault) dev_we[dev_sel] = 1'b1;
    end

    assign intc_rd  = cpu.cpu_addr[2] ? 32'(mask) : 32'(pending);
    assign rd_sel   = (state == S_IDLE) ? dev_sel : sel_q;
    assign dev_word = dev_rdata[{rd_sel, 5'd0} +: 32];

    assign dev_addr      = (state == S_IDLE) ? cpu.cpu_addr : addr_q;
    assign dev_wdata     = cpu.cpu_wdata;
    assign cpu.cpu_ready = (state == S_RESP);
    assign cpu.cpu_fault = (state == S_RESP) && fault_q;
    // DM is synchronous: its data arrives during RESP, so it bypasses the capture register.
    assign cpu.cpu_rdata = ((state == S_RESP) && dm_rd_q) ? dm_rdata : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            fault_q <= 1'b0;
            dm_rd_q <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (cpu.cpu_req) begin
                    addr_q  <= cpu.cpu_addr;
                    sel_q   <= dev_sel;
                    fault_q <= fault;
                    dm_rd_q <= hit_dm && !is_wr;
                    cnt     <= LAT_M1;
                    if (fault || is_wr)  rdata_q <= '0;
                    else if (hit_intc)   rdata_q <= intc_rd;
                    else if (hit_dev)    rdata_q <= dev_word;
                    else                 rdata_q <= '0;
                    state <= dev_rd_wait ? S_WAIT : S_RESP;
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= dev_word;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign src     = {ext_irq, irq};
    assign rise    = src & ~src_q;
    assign intc_wr = acc && hit_intc && is_wr && !fault;
    assign clr     = (intc_wr && !cpu.cpu_addr[2]) ? cpu.cpu_wdata[NSRC-1:0] : '0;

    // Rising edges are OR-ed in after the clear so a same-cycle edge survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '1;
        end else begin
            src_q   <= src;
            pending <= (pending & ~clr) | rise;
            if (intc_wr && cpu.cpu_addr[2]) mask <= cpu.cpu_wdata[NSRC-1:0];
        end
    end

    always_comb begin
        hwint = '0;
        hwint[NSRC-1:0] = pending & mask;
    end
endmodule

// File: tb/tb_bridge_multi.sv
// Self-checking bench for bridge_multi (NUM_DEV=2, DEV_LAT=3): directed scenarios
// plus randomized accesses checked against an address-map reference model.
module tb_bridge_multi;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bridge_multi_if cpu_if();
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata, dev_addr, dev_wdata;
    logic [1:0]  dev_we, irq;
    logic [63:0] dev_rdata;
    logic        ext_irq;
    logic [5:0]  hwint;

    bridge_multi #(.NUM_DEV(2), .DEV_LAT(3)) dut (
        .clk(clk), .reset(reset), .cpu(cpu_if),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we),
        .dev_rdata(dev_rdata), .irq(irq), .ext_irq(ext_irq), .hwint(hwint)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] pend_m, mask_m;

    logic [3:0]  a_dm_be;
    logic [1:0]  a_dev_we;
    logic [31:0] r_data;
    logic        r_fault;
    int          r_lat;
    bit          stray, unstable;

    // One access: strobes sampled in the accept cycle, then wait for ready.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = a; cpu_if.cpu_wdata = wd; cpu_if.cpu_byteen = be;
        #1;
        a_dm_be = dm_byteen; a_dev_we = dev_we; stray = 0; unstable = (dev_addr !== a);
        @(negedge clk);
        cpu_if.cpu_req = 1'b0;
        r_lat = 1;
        while (cpu_if.cpu_ready !== 1'b1 && r_lat < 40) begin
            if (dm_byteen !== 4'h0 || dev_we !== 2'b00) stray = 1;
            if (dev_addr !== a) unstable = 1;
            @(negedge clk);
            r_lat++;
        end
        if (dm_byteen !== 4'h0 || dev_we !== 2'b00) stray = 1;
        if (dev_addr !== a) unstable = 1;
        r_data = cpu_if.cpu_rdata; r_fault = cpu_if.cpu_fault;
    endtask

    // Address map: kind 0 DM, 1 device, 2 INTC, 3 unmapped.
    task automatic ref_access(input logic [31:0] a, input logic [3:0] be,
                              output int kind, output int idx, output bit flt, output int lat);
        kind = 3; idx = 0;
        if (a < 32'h3000) kind = 0;
        else begin
            for (int i = 1; i >= 0; i--)
                if (a >= 32'h7F00 + i * 16 && a < 32'h7F00 + i * 16 + 12) begin kind = 1; idx = i; end
            if (kind == 3 && a >= 32'h7F80 && a < 32'h7F88) kind = 2;
        end
        flt = (kind == 3) || ((kind == 1 || kind == 2) && (a[1:0] != 0 || (be != 0 && be != 4'hF)));
        lat = (kind == 1 && be == 0 && !flt) ? 4 : 1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cpu_if.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cpu_if.cpu_ready); end
        checks++; if (cpu_if.cpu_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", cpu_if.cpu_fault); end
        checks++; if (cpu_if.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", cpu_if.cpu_rdata); end
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL reset_hwint got %b exp 0", hwint); end
        checks++; if (dm_byteen !== 4'h0 || dev_we !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b/%b exp 0", dm_byteen, dev_we); end
        issue(32'h7F84, 32'h0, 4'h0);
        checks++; if (r_data !== 32'h7) begin errors++; $display("FAIL reset_mask got %h exp 7", r_data); end
        issue(32'h7F80, 32'h0, 4'h0);
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", r_data); end
    endtask

    task automatic test_dm_write();
        issue(32'h10, 32'h12345678, 4'b0011);
        checks++; if (a_dm_be !== 4'b0011) begin errors++; $display("FAIL dmw_byteen got %b exp 0011", a_dm_be); end
        checks++; if (a_dev_we !== 2'b00) begin errors++; $display("FAIL dmw_devwe got %b exp 00", a_dev_we); end
        checks++; if (stray) begin errors++; $display("FAIL dmw_stray got 1 exp 0"); end
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL dmw_lat got %0d exp 1", r_lat); end
        checks++; if (r_fault !== 1'b0) begin errors++; $display("FAIL dmw_fault got %b exp 0", r_fault); end
    endtask

    task automatic test_dev_read();
        dev_rdata = {32'hCAFE0001, 32'h5A5A0000 ^ $urandom};
        issue(32'h7F14, 32'h0, 4'h0);
        checks++; if (r_lat !== 4) begin errors++; $display("FAIL devrd_lat got %0d exp 4", r_lat); end
        checks++; if (r_data !== 32'hCAFE0001) begin errors++; $display("FAIL devrd_data got %h exp cafe0001", r_data); end
        checks++; if (unstable) begin errors++; $display("FAIL devrd_addr_stable got 1 exp 0"); end
        checks++; if (r_fault !== 1'b0) begin errors++; $display("FAIL devrd_fault got %b exp 0", r_fault); end
    endtask

    task automatic test_faults();
        issue(32'h7F00, 32'hFFFFFFFF, 4'b0001);
        checks++; if (a_dev_we !== 2'b00) begin errors++; $display("FAIL flt_devwe got %b exp 00", a_dev_we); end
        checks++; if (r_fault !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL flt_partial got %b/%h exp 1/0", r_fault, r_data); end
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL flt_lat got %0d exp 1", r_lat); end
        issue(32'h5000, 32'h0, 4'h0);
        checks++; if (r_fault !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL flt_5000 got %b/%h exp 1/0", r_fault, r_data); end
        issue(32'h7F0C, 32'h0, 4'h0);
        checks++; if (r_fault !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL flt_7f0c got %b/%0d exp 1/1", r_fault, r_lat); end
    endtask

    task automatic test_intc();
        @(negedge clk); irq[0] = 1'b1; #1;
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL intc_nocomb got %b exp 0", hwint); end
        @(negedge clk); irq[0] = 1'b0;
        checks++; if (hwint !== 6'b000001) begin errors++; $display("FAIL intc_set got %b exp 000001", hwint); end
        issue(32'h7F84, 32'h0, 4'hF);
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL intc_masked got %b exp 0", hwint); end
        issue(32'h7F80, 32'h0, 4'h0);
        checks++; if (r_data !== 32'h1) begin errors++; $display("FAIL intc_pend_rd got %h exp 1", r_data); end
        issue(32'h7F84, 32'h1, 4'hF);
        checks++; if (hwint !== 6'b000001) begin errors++; $display("FAIL intc_unmask got %b exp 000001", hwint); end
        issue(32'h7F80, 32'h1, 4'hF);
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL intc_clear got %b exp 0", hwint); end
        @(negedge clk);
        cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = 32'h7F80; cpu_if.cpu_wdata = 32'h1; cpu_if.cpu_byteen = 4'hF;
        irq[0] = 1'b1;
        @(negedge clk); cpu_if.cpu_req = 1'b0; irq[0] = 1'b0;
        checks++; if (cpu_if.cpu_ready !== 1'b1 || hwint !== 6'b000001) begin errors++; $display("FAIL intc_set_wins got %b/%b exp 1/000001", cpu_if.cpu_ready, hwint); end
        issue(32'h7F80, 32'h1, 4'hF);
        issue(32'h7F84, 32'h7, 4'hF);
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL intc_restore got %b exp 0", hwint); end
        pend_m = 3'b000; mask_m = 3'b111;
    endtask

    task automatic test_ext_irq();
        @(negedge clk); ext_irq = 1'b1; #1;
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL ext_nocomb got %b exp 0", hwint); end
        @(negedge clk);
        checks++; if (hwint !== 6'b000100) begin errors++; $display("FAIL ext_set got %b exp 000100", hwint); end
        issue(32'h7F80, 32'h4, 4'hF);
        repeat (3) @(negedge clk);
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL ext_level_hold got %b exp 0", hwint); end
        ext_irq = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [31:0] dv;
        bit data_ok;
        dv = $urandom; dm_rdata = dv; pat = '0; data_ok = 1;
        @(negedge clk);
        cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = 32'h20; cpu_if.cpu_byteen = 4'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat = {pat[4:0], cpu_if.cpu_ready};
            if (cpu_if.cpu_ready === 1'b1 && cpu_if.cpu_rdata !== dv) data_ok = 0;
        end
        cpu_if.cpu_req = 1'b0;
        checks++; if (pat !== 6'b101010) begin errors++; $display("FAIL b2b_pattern got %b exp 101010", pat); end
        checks++; if (!data_ok) begin errors++; $display("FAIL b2b_data got bad exp %h", dv); end
    endtask

    task automatic test_random();
        int kind, idx, lat, sel;
        bit flt;
        logic [31:0] a, wd, exp_d;
        logic [3:0] be;
        logic [31:0] unm [6];
        unm = '{32'h3000, 32'h5000, 32'h7F0C, 32'h7F20, 32'h7F88, 32'hFFFFFFF0};
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 2);
            be  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
            wd  = $urandom;
            case ($urandom_range(0, 5))
                0: a = $urandom_range(0, 32'h2FFF);
                1: a = 32'h7F00 + $urandom_range(0, 1) * 16 + $urandom_range(0, 2) * 4;
                2: a = 32'h7F00 + $urandom_range(0, 1) * 16 + $urandom_range(0, 11);
                3: a = 32'h7F80 + $urandom_range(0, 1) * 4;
                4: a = unm[$urandom_range(0, 5)];
                default: a = 32'h7F80 + $urandom_range(0, 7);
            endcase
            dm_rdata = $urandom; dev_rdata = {$urandom, $urandom};
            ref_access(a, be, kind, idx, flt, lat);
            exp_d = 32'h0;
            if (kind == 0) exp_d = dm_rdata;
            else if (kind == 1) exp_d = (idx == 1) ? dev_rdata[63:32] : dev_rdata[31:0];
            else if (kind == 2) exp_d = a[2] ? {29'h0, mask_m} : {29'h0, pend_m};
            issue(a, wd, be);
            if (kind == 2 && !flt && be != 0) begin
                if (a[2]) mask_m = wd[2:0]; else pend_m = pend_m & ~wd[2:0];
            end
            checks++; if (r_lat !== lat) begin errors++; $display("FAIL rnd_lat a=%h be=%h got %0d exp %0d", a, be, r_lat, lat); end
            checks++; if (r_fault !== flt) begin errors++; $display("FAIL rnd_fault a=%h be=%h got %b exp %b", a, be, r_fault, flt); end
            checks++; if (a_dm_be !== ((kind == 0) ? be : 4'h0)) begin errors++; $display("FAIL rnd_dm_be a=%h got %b exp %b", a, a_dm_be, (kind == 0) ? be : 4'h0); end
            checks++; if (a_dev_we !== ((kind == 1 && be != 0 && !flt) ? 2'(1 << idx) : 2'b00)) begin errors++; $display("FAIL rnd_dev_we a=%h be=%h got %b", a, be, a_dev_we); end
            checks++; if (stray) begin errors++; $display("FAIL rnd_stray a=%h got 1 exp 0", a); end
            if (flt || be == 0) begin
                checks++; if (r_data !== (flt ? 32'h0 : exp_d)) begin errors++; $display("FAIL rnd_rdata a=%h got %h exp %h", a, r_data, flt ? 32'h0 : exp_d); end
            end
            checks++; if (hwint !== {3'b000, pend_m & mask_m}) begin errors++; $display("FAIL rnd_hwint got %b exp %b", hwint, {3'b000, pend_m & mask_m}); end
        end
    endtask

    task automatic test_reset_wait();
        bit seen;
        logic [31:0] dv;
        @(negedge clk);
        cpu_if.cpu_req = 1'b1; cpu_if.cpu_addr = 32'h7F00; cpu_if.cpu_byteen = 4'h0;
        @(negedge clk); cpu_if.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0; irq[1] = 1'b1; #1;
        seen = (cpu_if.cpu_ready === 1'b1);
        repeat (3) begin @(negedge clk); if (cpu_if.cpu_ready === 1'b1) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL rstw_ready got 1 exp 0"); end
        reset = 1'b1; #1;
        pend_m = 3'b000; mask_m = 3'b111;
        checks++; if (cpu_if.cpu_ready !== 1'b0 || cpu_if.cpu_fault !== 1'b0 || cpu_if.cpu_rdata !== 32'h0)
            begin errors++; $display("FAIL rstw_outputs got %b/%b/%h exp 0/0/0", cpu_if.cpu_ready, cpu_if.cpu_fault, cpu_if.cpu_rdata); end
        checks++; if (hwint !== 6'h0 || dm_byteen !== 4'h0 || dev_we !== 2'b00) begin errors++; $display("FAIL rstw_lines got %b/%b/%b exp 0", hwint, dm_byteen, dev_we); end
        @(negedge clk);
        pend_m[1] = 1'b1;
        checks++; if (hwint !== 6'b000010) begin errors++; $display("FAIL rstw_held_src got %b exp 000010", hwint); end
        irq[1] = 1'b0;
        dv = $urandom; dm_rdata = dv;
        issue(32'h100, 32'h0, 4'h0);
        checks++; if (r_lat !== 1 || r_data !== dv || r_fault !== 1'b0) begin errors++; $display("FAIL rstw_new_req got %0d/%h/%b exp 1/%h/0", r_lat, r_data, r_fault, dv); end
        issue(32'h7F80, 32'h2, 4'hF);
        checks++; if (hwint !== 6'h0) begin errors++; $display("FAIL rstw_clear got %b exp 0", hwint); end
    endtask

    initial begin
        cpu_if.cpu_req = 1'b0; cpu_if.cpu_addr = '0; cpu_if.cpu_wdata = '0; cpu_if.cpu_byteen = '0;
        dm_rdata = '0; dev_rdata = '0; irq = '0; ext_irq = 1'b0;
        pend_m = 3'b000; mask_m = 3'b111;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_dm_write();
        test_dev_read();
        test_faults();
        test_intc();
        test_ext_irq();
        test_back_to_back();
        test_random();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bridge_multi.md
# bridge_multi

Parametrised system bridge between the CPU memory stage and the data memory, NUM_DEV word-register devices (timers) and a built-in interrupt controller. It decodes addresses, steers write strobes, returns read data through a one-request-at-a-time ready handshake with configurable device read latency, and flags unmapped or illegal accesses. It latches peripheral and external interrupts into a maskable pending register that drives the CP0 `hwint` lines.

## Interface
- `NUM_DEV`, 2: device count, 1..5
- `DM_SIZE`, 32'h3000: DM window [0, DM_SIZE)
- `DEV_BASE`, 32'h7F00: device 0 base; device i at DEV_BASE + i*DEV_STRIDE
- `DEV_STRIDE`, 32'h10: byte spacing between device windows
- `DEV_SPAN`, 32'hC: bytes decoded per device window
- `INTC_BASE`, 32'h7F80: +0 pending (read / write-1-to-clear), +4 mask (read/write)
- `DEV_LAT`, 1: extra wait cycles for device reads, 0..15
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low
- `cpu_req` in 1: access request, sampled only in IDLE
- `cpu_addr` in 32: byte address
- `cpu_wdata` in 32: write data
- `cpu_byteen` in 4: write byte enables; 0 = read
- `cpu_rdata` out 32: read data, valid with `cpu_ready`
- `cpu_ready` out 1: one-cycle completion pulse
- `cpu_fault` out 1: access error, valid with `cpu_ready`
- `dm_byteen` out 4: DM write strobes
- `dm_rdata` in 32: DM synchronous read data
- `dev_addr` out 32: shared device address
- `dev_wdata` out 32: shared device write data
- `dev_we` out NUM_DEV: one-hot device write enable
- `dev_rdata` in 32*NUM_DEV: device i read data at bits [32i+31:32i]
- `irq` in NUM_DEV: device interrupt levels
- `ext_irq` in 1: external interrupt level
- `hwint` out 6: interrupt lines to CP0

## Operation
- FSM: IDLE, WAIT, RESP. IDLE + `cpu_req` = accept; address/byteen/kind latched.
- Decode (first match): DM, device i (offset < DEV_SPAN), INTC (+0, +4), else unmapped.
- Fault when: unmapped; device/INTC access with addr[1:0] != 0; device/INTC write with byteen != 4'hF. Faulting access writes nothing.
- Writes: strobe asserted combinationally in accept cycle only: `dm_byteen` = cpu_byteen for DM, `dev_we[i]` for device i, INTC register updated at accept edge. All strobes 0 otherwise.
- Reads: DM and INTC captured into `cpu_rdata` at IDLE->RESP edge... DM data = `dm_rdata` sampled at the RESP edge; device read goes IDLE->WAIT (if DEV_LAT>0), down-counter DEV_LAT, then ->RESP, capturing selected `dev_rdata`.
- `dev_addr` = cpu_addr in IDLE, latched address in WAIT/RESP; `dev_wdata` = cpu_wdata.
- RESP: `cpu_ready`=1 one cycle, then IDLE. Fault responses: `cpu_fault`=1, `cpu_rdata`=0. `cpu_req` outside IDLE ignored.
- Interrupt sources: bit i = irq[i] (i<NUM_DEV), bit NUM_DEV = ext_irq. Edge detector per source (previous-value reg reset 0); rising edge sets pending bit.
- Pending clear by INTC+0 write: bits with wdata=1 cleared; same-cycle set wins over clear.
- `hwint[k]` = pending[k] & mask[k] for k<=NUM_DEV; higher bits 0. Registered (from flops), no comb path from `irq`.
- Reads of INTC return zero-extended pending / mask.

## Timing
- Reset values: state IDLE, `cpu_ready`=0, `cpu_fault`=0, `cpu_rdata`=0, pending=0, mask=all ones, edge regs=0, `hwint`=0; `dm_byteen`/`dev_we`=0.
- Latency accept->ready: DM, INTC, any write, any fault: 1 cycle; device read: 1+DEV_LAT cycles.
- Back-to-back: next accept earliest in cycle after `cpu_ready`; throughput one access per 2 cycles (DM).
- Interrupt: irq rises at edge n -> pending set at n+1 -> `hwint` high same cycle as pending.
- Reset mid-WAIT/RESP: immediate return to IDLE, no `cpu_ready`, latched request dropped.
- Source held high through reset release: one edge seen, pending set after first clock.

## Test plan
- DM write addr 0x10, byteen 4'b0011 -> `dm_byteen`=0011 for exactly the accept cycle; `cpu_ready` next cycle, `cpu_fault`=0.
- DEV_LAT=3, read 0x7F14 (device 1, offset 4), dev_rdata[63:32]=32'hCAFE0001 -> `cpu_ready` 4 cycles after accept, `cpu_rdata`=32'hCAFE0001, `dev_addr` stable 0x7F14 throughout.
- Write 0x7F00 byteen 4'b0001 -> no `dev_we`, `cpu_fault`=1, `cpu_rdata`=0; read 0x5000 -> fault; read 0x7F0C -> fault.
- irq[0] pulses; mask write 0x7F84 = 0 -> `hwint`=0 with pending[0]=1 readable at 0x7F80; mask=1 -> `hwint[0]`=1; write 0x7F80 = 1 -> clears; simultaneous new edge and clear -> pending stays 1.
- ext_irq rise with NUM_DEV=2 -> `hwint`=6'b000100 after one cycle; level held does not re-set after clear.
- Reset asserted during WAIT -> no `cpu_ready`; after release all outputs at reset values and new request served normally.
